// File: rtl/wdt_pkg.sv
// Shared constants for the windowed watchdog: register map, CTRL/STATUS bit
// positions and the default kick key.
package wdt_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PRESC  = 3'd1;
    localparam logic [2:0] ADDR_TOUT_L = 3'd2;
    localparam logic [2:0] ADDR_TOUT_H = 3'd3;
    localparam logic [2:0] ADDR_WIN_L  = 3'd4;
    localparam logic [2:0] ADDR_WIN_H  = 3'd5;
    localparam logic [2:0] ADDR_CNT_L  = 3'd4;
    localparam logic [2:0] ADDR_CNT_H  = 3'd5;
    localparam logic [2:0] ADDR_KICK   = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_WIN_EN = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_LOCK   = 3;

    localparam int ST_TO  = 0;
    localparam int ST_WV  = 1;
    localparam int ST_IRQ = 2;
    localparam int ST_RUN = 3;

    localparam logic [7:0] DEFAULT_KICK_KEY = 8'hA5;

endpackage

// File: rtl/wdt_prescaler.sv
// 8-bit prescaler: counts 0..presc while run is high and emits a one-cycle
// tick on the terminal value.
module wdt_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clr,
    input  logic [7:0] presc,
    output logic       tick
);

    logic [7:0] cnt;

    // >= rather than == so a PRESC lowered below the running count wraps at once.
    assign tick = run && (cnt >= presc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= 8'd0;
        else if (clr || tick)
            cnt <= 8'd0;
        else if (run)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/wdt_window_timer.sv
// Windowed watchdog on the TV80 I/O bus: prescaled down-counter, keyed kick,
// pre-timeout interrupt and a stretched CPU reset request.
module wdt_window_timer
    import wdt_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter int         RST_LEN   = 16,
    parameter int         PRE_TICKS = 16,
    parameter logic [7:0] KICK_KEY  = DEFAULT_KICK_KEY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       int_n,
    output logic       wdt_reset
);

    localparam int PW = $clog2(RST_LEN + 1);

    logic             en, win_en, irq_en, lock;
    logic [7:0]       presc;
    logic [CNT_W-1:0] tout, win, count;
    logic             sts_to, sts_wv, sts_irq;
    logic [PW-1:0]    pulse_cnt;
    logic             write_sel_q;

    logic write_sel, read_sel, wr_pulse, cfg_wr, kick_wr, kick_ok, kick_bad;
    logic tick, timeout, trigger, en_rise, irq_hit, w1c;

    assign write_sel = !cs_n && rd_n && !wr_n;
    assign read_sel  = !cs_n && !rd_n && wr_n;
    assign wr_pulse  = write_sel && !write_sel_q;
    assign cfg_wr    = wr_pulse && !lock;
    assign w1c       = wr_pulse && (addr == ADDR_STATUS);

    assign kick_wr  = wr_pulse && (addr == ADDR_KICK) && en;
    assign kick_ok  = kick_wr && (data_in == KICK_KEY) && (!win_en || count <= win);
    assign kick_bad = kick_wr && !kick_ok;

    // A valid kick landing on the expiring tick rescues the count.
    assign timeout = tick && (count == '0) && !kick_ok;
    assign trigger = timeout || kick_bad;
    assign en_rise = cfg_wr && (addr == ADDR_CTRL) && data_in[CTRL_EN] && !en;
    assign irq_hit = en && irq_en && (count <= CNT_W'(PRE_TICKS));
    assign int_n   = !(sts_irq && irq_en);

    wdt_prescaler u_presc (
        .clk   (clk),
        .reset (reset),
        .run   (en && pause_n),
        .clr   (en_rise || kick_ok),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en          <= 1'b0;
            win_en      <= 1'b0;
            irq_en      <= 1'b0;
            lock        <= 1'b0;
            presc       <= 8'd0;
            tout        <= '1;
            win         <= '0;
            count       <= '1;
            sts_to      <= 1'b0;
            sts_wv      <= 1'b0;
            sts_irq     <= 1'b0;
            pulse_cnt   <= '0;
            wdt_reset   <= 1'b0;
            write_sel_q <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments; later
            // statements in this block deliberately override earlier ones.
            write_sel_q <= write_sel;

            if (cfg_wr) begin
                case (addr)
                    ADDR_CTRL: begin
                        en     <= data_in[CTRL_EN];
                        win_en <= data_in[CTRL_WIN_EN];
                        irq_en <= data_in[CTRL_IRQ_EN];
                        if (data_in[CTRL_LOCK])
                            lock <= 1'b1;
                    end
                    ADDR_PRESC:  presc <= data_in;
                    ADDR_TOUT_L: tout[7:0] <= data_in;
                    ADDR_TOUT_H: tout[CNT_W-1:8] <= data_in[CNT_W-9:0];
                    ADDR_WIN_L:  win[7:0] <= data_in;
                    ADDR_WIN_H:  win[CNT_W-1:8] <= data_in[CNT_W-9:0];
                    default: ;
                endcase
            end

            if (trigger || en_rise || kick_ok)
                count <= tout;
            else if (tick)
                count <= count - CNT_W'(1);

            if (trigger)
                en <= 1'b0;

            // Flag sets are ordered after write-1-to-clear so a coincident set wins.
            if (w1c && data_in[ST_TO])  sts_to <= 1'b0;
            if (w1c && data_in[ST_WV])  sts_wv <= 1'b0;
            if (w1c && data_in[ST_IRQ]) sts_irq <= 1'b0;
            if (timeout)  sts_to <= 1'b1;
            if (kick_bad) sts_wv <= 1'b1;
            if (irq_hit)  sts_irq <= 1'b1;
            if (kick_ok)  sts_irq <= 1'b0;

            if (wdt_reset) begin
                if (pulse_cnt == '0)
                    wdt_reset <= 1'b0;
                else
                    pulse_cnt <= pulse_cnt - PW'(1);
            end else if (trigger) begin
                wdt_reset <= 1'b1;
                pulse_cnt <= PW'(RST_LEN - 1);
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves data_out unassigned (no latch).
        data_out = 8'h00;
        if (read_sel) begin
            case (addr)
                ADDR_CTRL:   data_out = {4'b0, lock, irq_en, win_en, en};
                ADDR_PRESC:  data_out = presc;
                ADDR_TOUT_L: data_out = tout[7:0];
                ADDR_TOUT_H: data_out = 8'(tout >> 8);
                ADDR_CNT_L:  data_out = count[7:0];
                ADDR_CNT_H:  data_out = 8'(count >> 8);
                ADDR_STATUS: data_out = {4'b0, en, sts_irq, sts_wv, sts_to};
                default:     data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_wdt_window_timer.sv
// Directed bench for wdt_window_timer: timeout, kicks, window, bad key,
// pre-timeout interrupt, pause, lock and async reset.
module tb_wdt_window_timer;
    import wdt_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pause_n = 1'b1;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       int_n, wdt_reset;

    int checks = 0;
    int errors = 0;

    wdt_window_timer dut (
        .clk       (clk),
        .reset     (reset),
        .pause_n   (pause_n),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .int_n     (int_n),
        .wdt_reset (wdt_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data_in = d; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        addr = a; cs_n = 1'b0; rd_n = 1'b0;
        #1 d = data_out;
        cs_n = 1'b1; rd_n = 1'b1;
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        check(tag, {8'h00, v}, {8'h00, exp});
    endtask

    task automatic wait_cnt(input string tag, input logic [7:0] target);
        logic [7:0] v;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            bus_read(ADDR_CNT_L, v);
            n++;
        end while (v != target && n < 1000);
        check(tag, {8'h00, v}, {8'h00, target});
    endtask

    initial begin
        int n, len, hi;
        logic [7:0] v;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_wdt_reset", wdt_reset, 0);
        check("rst_int_n", int_n, 1);
        check_reg("rst_ctrl", ADDR_CTRL, 8'h00);
        check_reg("rst_presc", ADDR_PRESC, 8'h00);
        check_reg("rst_tout_l", ADDR_TOUT_L, 8'hFF);
        check_reg("rst_tout_h", ADDR_TOUT_H, 8'hFF);
        check_reg("rst_cnt_l", ADDR_CNT_L, 8'hFF);
        check_reg("rst_cnt_h", ADDR_CNT_H, 8'hFF);
        check_reg("rst_status", ADDR_STATUS, 8'h00);
        check_reg("read_addr6", ADDR_KICK, 8'h00);
        addr = ADDR_TOUT_L; rd_n = 1'b0; #1;
        check("unselected_bus", data_out, 8'h00);
        rd_n = 1'b1;

        // Plain timeout, PRESC=0: rises on the 6th tick, 16 cycles long
        bus_write(ADDR_TOUT_L, 8'd5);
        bus_write(ADDR_TOUT_H, 8'd0);
        bus_write(ADDR_CTRL, 8'h01);
        check_reg("en_loads_tout", ADDR_CNT_L, 8'd5);
        n = 0;
        while (!wdt_reset && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("timeout_latency", 16'(n), 16'd6);
        len = 0;
        while (wdt_reset && len < 100) begin
            len++; @(posedge clk); #1;
        end
        check("pulse_len", 16'(len), 16'd16);
        check_reg("to_status", ADDR_STATUS, 8'h01);
        check_reg("to_ctrl_en_clr", ADDR_CTRL, 8'h00);
        bus_write(ADDR_STATUS, 8'h07);
        check_reg("w1c_status", ADDR_STATUS, 8'h00);

        // Regular kicks keep it alive
        bus_write(ADDR_PRESC, 8'd3);
        bus_write(ADDR_TOUT_L, 8'd100);
        bus_write(ADDR_CTRL, 8'h01);
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (200) begin
                @(negedge clk);
                if (wdt_reset) hi++;
            end
            bus_write(ADDR_KICK, 8'hA5);
            check_reg("kick_reload", ADDR_CNT_L, 8'd100);
        end
        check("no_reset_with_kicks", 16'(hi), 16'd0);
        check_reg("running_status", ADDR_STATUS, 8'h08);

        // Pause freezes the count; kick still works while paused
        repeat (50) @(negedge clk);
        pause_n = 1'b0;
        repeat (20) @(negedge clk);
        check_reg("pause_frozen", ADDR_CNT_L, 8'd88);
        bus_write(ADDR_KICK, 8'hA5);
        check_reg("pause_kick", ADDR_CNT_L, 8'd100);
        pause_n = 1'b1;
        bus_write(ADDR_CTRL, 8'h00);

        // Window: early kick violates, in-window kick reloads
        bus_write(ADDR_TOUT_L, 8'd50);
        bus_write(ADDR_WIN_L, 8'd10);
        bus_write(ADDR_WIN_H, 8'd0);
        bus_write(ADDR_CTRL, 8'h03);
        wait_cnt("reach_40", 8'd40);
        bus_write(ADDR_KICK, 8'hA5);
        check("early_kick_reset", wdt_reset, 1);
        check_reg("early_kick_status", ADDR_STATUS, 8'h02);
        check_reg("trigger_reload", ADDR_CNT_L, 8'd50);
        repeat (20) @(negedge clk);
        check("pulse_ended", wdt_reset, 0);
        bus_write(ADDR_STATUS, 8'h07);
        bus_write(ADDR_CTRL, 8'h03);
        wait_cnt("reach_8", 8'd8);
        bus_write(ADDR_KICK, 8'hA5);
        @(negedge clk);
        check("window_kick_no_reset", wdt_reset, 0);
        check_reg("window_kick_reload", ADDR_CNT_L, 8'd50);
        check_reg("window_kick_status", ADDR_STATUS, 8'h08);

        // Bad key while enabled, then while disabled
        bus_write(ADDR_CTRL, 8'h01);
        bus_write(ADDR_KICK, 8'h5A);
        check("bad_key_reset", wdt_reset, 1);
        check_reg("bad_key_status", ADDR_STATUS, 8'h02);
        repeat (20) @(negedge clk);
        bus_write(ADDR_STATUS, 8'h07);
        bus_write(ADDR_KICK, 8'h5A);
        repeat (2) @(negedge clk);
        check("bad_key_dis_reset", wdt_reset, 0);
        check_reg("bad_key_dis_status", ADDR_STATUS, 8'h00);

        // Pre-timeout interrupt
        bus_write(ADDR_TOUT_L, 8'd20);
        bus_write(ADDR_CTRL, 8'h05);
        wait_cnt("reach_17", 8'd17);
        check("int_n_above", int_n, 1);
        wait_cnt("reach_16", 8'd16);
        repeat (2) @(negedge clk);
        check("int_n_low", int_n, 0);
        check_reg("irq_status", ADDR_STATUS, 8'h0C);
        bus_write(ADDR_STATUS, 8'h04);
        @(negedge clk);
        check("int_n_sticky", int_n, 0);
        bus_write(ADDR_KICK, 8'hA5);
        check("int_n_kick", int_n, 1);
        check_reg("irq_kick_reload", ADDR_CNT_L, 8'd20);
        check_reg("irq_kick_status", ADDR_STATUS, 8'h08);

        // Lock, then async reset in the middle of the pulse
        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_PRESC, 8'd0);
        bus_write(ADDR_TOUT_L, 8'd5);
        bus_write(ADDR_CTRL, 8'h09);
        check_reg("lock_ctrl", ADDR_CTRL, 8'h09);
        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_PRESC, 8'd7);
        check_reg("lock_ctrl_kept", ADDR_CTRL, 8'h09);
        check_reg("lock_presc_kept", ADDR_PRESC, 8'h00);
        n = 0;
        while (!wdt_reset && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("lock_timeout", wdt_reset, 1);
        check_reg("lock_after_trigger", ADDR_CTRL, 8'h08);
        repeat (5) @(negedge clk);
        check("mid_pulse", wdt_reset, 1);
        reset = 1'b1;
        #1;
        check("async_reset_drop", wdt_reset, 0);
        check_reg("ar_ctrl", ADDR_CTRL, 8'h00);
        check_reg("ar_presc", ADDR_PRESC, 8'h00);
        check_reg("ar_tout_l", ADDR_TOUT_L, 8'hFF);
        check_reg("ar_cnt_l", ADDR_CNT_L, 8'hFF);
        check_reg("ar_status", ADDR_STATUS, 8'h00);
        check("ar_int_n", int_n, 1);
        @(negedge clk);
        reset = 1'b0;
        bus_write(ADDR_PRESC, 8'd7);
        check_reg("unlocked_presc", ADDR_PRESC, 8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
